icache_dm_sram: RTL
===================

// Module: icache_dm_sram
// PURPOSE
// - Blocking, direct-mapped, read-only instruction cache between the core's SRAM-like inst port and the inst port of cpu_axi_interface.
// - Hits return from local storage; misses refill a whole line as LINE_WORDS single-word SRAM-like reads.
// - Uncached fetches bypass as one single-word read.
// PARAMETERS
// - LINE_WORDS  4   32-bit words per line; power of 2, >=2
// - SETS        64  number of lines; power of 2
// - Derived: OFF_W=log2(LINE_WORDS*4), IDX_W=log2(SETS), TAG_W=32-OFF_W-IDX_W
// PORTS
// - aclk          in   1   clock
// - aresetn       in   1   reset; asynchronous, active-low
// - cpu_req       in   1   fetch request; held until cpu_addr_ok
// - cpu_wr        in   1   must be 0; ignored
// - cpu_size      in   2   must be 2'b10; ignored
// - cpu_addr      in   32  fetch address, word-aligned
// - cpu_uncached  in   1   bypass the cache for this request
// - cpu_inv_all   in   1   one-cycle pulse: invalidate all lines
// - cpu_addr_ok   out  1   request accepted this cycle
// - cpu_data_ok   out  1   one-cycle pulse: cpu_rdata valid
// - cpu_rdata     out  32  fetched instruction
// - mem_req       out  1   downstream request; held until mem_addr_ok
// - mem_wr        out  1   tied 0
// - mem_size      out  2   tied 2'b10
// - mem_addr      out  32  downstream word address
// - mem_wstrb     out  4   tied 0
// - mem_wdata     out  32  tied 0
// - mem_addr_ok   in   1   downstream accepted request
// - mem_data_ok   in   1   downstream read data valid
// - mem_rdata     in   32  downstream read data
// BEHAVIOUR
// - Reset values
//   - state=IDLE; all valid bits 0; refill counter 0; inv_pend 0.
//   - Outputs: cpu_addr_ok=0, cpu_data_ok=0, cpu_rdata=0, mem_req=0, mem_addr=0.
// - Reset mid-operation
//   - Abandons the refill or bypass in progress. The partial line stays invalid.
//   - No cpu_data_ok is issued for the abandoned request.
// - Protocols
//   - Handshake on both sides: a request completes when req&&addr_ok.
//   - Responses return in order.
//   - At most one outstanding request per side.
// - cpu_addr_ok = cpu_req && state==IDLE && !inv_pend (combinational).
//   - On acceptance, latch addr and uncached, then go to LOOKUP.
// - LOOKUP (1 cycle)
//   - uncached -> UC_REQ.
//   - Hit (valid[idx] && tag match) -> cpu_data_ok=1 with word[addr[OFF_W-1:2]] -> IDLE.
//   - Hit latency: data_ok is asserted in the cycle after addr_ok.
//   - Miss -> MISS_REQ with cnt=0.
// - MISS_REQ
//   - mem_req=1, mem_addr={tag,idx,cnt,2'b00}.
//   - On mem_addr_ok -> MISS_WAIT.
// - MISS_WAIT
//   - On mem_data_ok: write mem_rdata into line word cnt.
//   - If cnt==LINE_WORDS-1: set tag and valid, then go to REFILL_RSP. Otherwise cnt++ and go to MISS_REQ.
// - REFILL_RSP
//   - cpu_data_ok=1 with the requested word (forwarded from the line just written) -> IDLE.
// - UC_REQ
//   - mem_req=1 with the latched address; on mem_addr_ok -> UC_WAIT.
// - UC_WAIT
//   - On mem_data_ok: cpu_data_ok=1, cpu_rdata=mem_rdata (same cycle) -> IDLE.
//   - The cache is not written.
// - cpu_inv_all
//   - In IDLE, clears all valid bits at the next edge. It has priority over a cpu_req in the same cycle; cpu_addr_ok=0 that cycle.
//   - When not in IDLE, sets inv_pend; the clear happens on return to IDLE, then inv_pend=0.
//   - A line refilled during the pending period is also cleared.
// - cpu_req in a non-IDLE state is not accepted; the requester holds it.
// - mem_addr_ok and mem_data_ok in the same cycle are impossible per protocol; if seen in MISS_REQ, mem_data_ok is ignored.
// - Unexpected mem_data_ok (in IDLE or LOOKUP) is ignored.
// - Address index and tag are fixed at acceptance. cpu_addr changes after addr_ok have no effect.
// STRUCTURE
// - icache_pkg: state enum (IDLE, LOOKUP, MISS_REQ, MISS_WAIT, REFILL_RSP, UC_REQ, UC_WAIT), OFF_W/IDX_W/TAG_W functions, tied constants for mem_size and mem_wstrb.
// - Sub-module icache_line_store:
//   - Contains the tag/valid/data arrays (flop arrays) with one write port (word granularity plus a tag-valid set) and one asynchronous read port.
//   - Has a bulk valid clear.
//   - Valid bits are reset by aresetn.
// - Top level holds the FSM, the refill counter, and the latched request.
// TESTING
// - Cold miss:
//   - Stimulus: fetch 0x1C000010 with LINE_WORDS=4; memory word = addr ^ 0xA5A5A5A5.
//   - Response: exactly 4 mem requests at 0x1C000010, 0x1C000014, 0x1C000018, 0x1C00001C.
//   - Then one cpu_data_ok with 0xB9A5A5B5.
// - Hit:
//   - Stimulus: refetch 0x1C000018.
//   - Response: no mem_req; cpu_data_ok one cycle after addr_ok with 0xB9A5A5BD.
// - Conflict eviction:
//   - Stimulus: fetch 0x1C000410 (same index, different tag), then 0x1C000010.
//   - Response: both miss and refill (8 mem requests total).
// - Uncached:
//   - Stimulus: fetch 0x1FE00000 with cpu_uncached=1, issued twice.
//   - Response: each fetch issues exactly one mem request; a hit never occurs.
// - Invalidate:
//   - Stimulus: pulse cpu_inv_all during a refill, then refetch that line.
//   - Response: the refetch misses and refills again.
//   - Also: cpu_inv_all coinciding with cpu_req in IDLE -> cpu_addr_ok=0 that cycle.
// - Reset mid-refill:
//   - Stimulus: drop aresetn after 2 of 4 words, release it, then fetch the same line.
//   - Response: a full 4-word refill; all outputs are at reset values while reset is active.
// - Random downstream stalls (0-5 cycles on addr_ok and data_ok) plus a scoreboard against a memory model: no mismatches over 10k fetches.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared types and helpers for the direct-mapped instruction cache.
package icache_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLookup,
    StMissReq,
    StMissWait,
    StRefillRsp,
    StUcReq,
    StUcWait
  } state_e;

  localparam logic [1:0] MemSize  = 2'b10;
  localparam logic [3:0] MemWstrb = 4'b0000;

  function automatic int unsigned off_w(input int unsigned line_words);
    return $clog2(line_words * 4);
  endfunction

  function automatic int unsigned idx_w(input int unsigned sets);
    return $clog2(sets);
  endfunction

  function automatic int unsigned tag_w(input int unsigned line_words, input int unsigned sets);
    return 32 - off_w(line_words) - idx_w(sets);
  endfunction

endpackage

// File: rtl/icache_line_store.sv
// Tag/valid/data flop arrays: one word-granular write port, one asynchronous read port.
module icache_line_store
  import icache_pkg::*;
#(
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned SETS       = 64,
  localparam int unsigned IdxW      = idx_w(SETS),
  localparam int unsigned TagW      = tag_w(LINE_WORDS, SETS),
  localparam int unsigned WordW     = off_w(LINE_WORDS) - 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_all_i,
  input  logic             we_i,
  input  logic [IdxW-1:0]  widx_i,
  input  logic [WordW-1:0] wword_i,
  input  logic [31:0]      wdata_i,
  input  logic             set_valid_i,
  input  logic [TagW-1:0]  wtag_i,
  input  logic [IdxW-1:0]  ridx_i,
  input  logic [WordW-1:0] rword_i,
  output logic             rvalid_o,
  output logic [TagW-1:0]  rtag_o,
  output logic [31:0]      rdata_o
);

  logic [SETS-1:0] valid_q;
  logic [TagW-1:0] tag_q  [SETS];
  logic [31:0]     data_q [SETS][LINE_WORDS];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
    end else if (clear_all_i) begin
      valid_q <= '0;
    end else if (set_valid_i) begin
      valid_q[widx_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (set_valid_i) tag_q[widx_i] <= wtag_i;
    if (we_i) data_q[widx_i][wword_i] <= wdata_i;
  end

  assign rvalid_o = valid_q[ridx_i];
  assign rtag_o   = tag_q[ridx_i];
  assign rdata_o  = data_q[ridx_i][rword_i];

endmodule

// File: rtl/icache_dm_sram.sv
// Blocking direct-mapped read-only I-cache between an SRAM-like core port and memory port.
module icache_dm_sram
  import icache_pkg::*;
#(
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned SETS       = 64
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        cpu_req,
  input  logic        cpu_wr,
  input  logic [1:0]  cpu_size,
  input  logic [31:0] cpu_addr,
  input  logic        cpu_uncached,
  input  logic        cpu_inv_all,
  output logic        cpu_addr_ok,
  output logic        cpu_data_ok,
  output logic [31:0] cpu_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned OffW  = off_w(LINE_WORDS);
  localparam int unsigned IdxW  = idx_w(SETS);
  localparam int unsigned TagW  = tag_w(LINE_WORDS, SETS);
  localparam int unsigned WordW = OffW - 2;

  state_e           state_q;
  logic [WordW-1:0] cnt_q;
  logic [31:2]      addr_q;
  logic             uc_q;
  logic             inv_pend_q;

  logic [IdxW-1:0]  idx;
  logic [TagW-1:0]  tag;
  logic [WordW-1:0] word;
  logic             st_valid;
  logic [TagW-1:0]  st_tag;
  logic [31:0]      st_data;
  logic             hit;
  logic             last;
  logic             refill_we;
  logic             clear_all;
  logic             unused_ok;

  assign idx  = addr_q[OffW +: IdxW];
  assign tag  = addr_q[31 -: TagW];
  assign word = addr_q[OffW-1:2];
  assign hit  = st_valid && (st_tag == tag);
  assign last = (cnt_q == WordW'(LINE_WORDS - 1));

  assign refill_we = (state_q == StMissWait) && mem_data_ok;
  // A pending invalidate also wipes any line refilled while it was pending.
  assign clear_all = (state_q == StIdle) && (cpu_inv_all || inv_pend_q);

  // Gated by aresetn so the handshake reads as idle throughout reset.
  assign cpu_addr_ok = aresetn && cpu_req && (state_q == StIdle) && !inv_pend_q && !cpu_inv_all;

  assign unused_ok = ^{cpu_wr, cpu_size, cpu_addr[1:0]};

  icache_line_store #(
    .LINE_WORDS(LINE_WORDS),
    .SETS      (SETS)
  ) u_store (
    .clk_i      (aclk),
    .rst_ni     (aresetn),
    .clear_all_i(clear_all),
    .we_i       (refill_we),
    .widx_i     (idx),
    .wword_i    (cnt_q),
    .wdata_i    (mem_rdata),
    .set_valid_i(refill_we && last),
    .wtag_i     (tag),
    .ridx_i     (idx),
    .rword_i    (word),
    .rvalid_o   (st_valid),
    .rtag_o     (st_tag),
    .rdata_o    (st_data)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      addr_q     <= '0;
      uc_q       <= 1'b0;
      inv_pend_q <= 1'b0;
    end else begin
      if (state_q == StIdle) inv_pend_q <= 1'b0;
      else if (cpu_inv_all)  inv_pend_q <= 1'b1;
      unique case (state_q)
        StIdle: begin
          if (cpu_addr_ok) begin
            addr_q  <= cpu_addr[31:2];
            uc_q    <= cpu_uncached;
            state_q <= StLookup;
          end
        end
        StLookup: begin
          if (uc_q) begin
            state_q <= StUcReq;
          end else if (hit) begin
            state_q <= StIdle;
          end else begin
            cnt_q   <= '0;
            state_q <= StMissReq;
          end
        end
        StMissReq:   if (mem_addr_ok) state_q <= StMissWait;
        StMissWait: begin
          if (mem_data_ok) begin
            if (last) begin
              state_q <= StRefillRsp;
            end else begin
              cnt_q   <= cnt_q + WordW'(1);
              state_q <= StMissReq;
            end
          end
        end
        StRefillRsp: state_q <= StIdle;
        StUcReq:     if (mem_addr_ok) state_q <= StUcWait;
        StUcWait:    if (mem_data_ok) state_q <= StIdle;
        default:     state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    cpu_data_ok = 1'b0;
    cpu_rdata   = '0;
    mem_req     = 1'b0;
    mem_addr    = '0;
    unique case (state_q)
      StLookup: begin
        if (!uc_q && hit) begin
          cpu_data_ok = 1'b1;
          cpu_rdata   = st_data;
        end
      end
      StRefillRsp: begin
        cpu_data_ok = 1'b1;
        cpu_rdata   = st_data;
      end
      StMissReq: begin
        mem_req  = 1'b1;
        mem_addr = {addr_q[31:OffW], cnt_q, 2'b00};
      end
      StUcReq: begin
        mem_req  = 1'b1;
        mem_addr = {addr_q, 2'b00};
      end
      StUcWait: begin
        if (mem_data_ok) begin
          cpu_data_ok = 1'b1;
          cpu_rdata   = mem_rdata;
        end
      end
      default: ;
    endcase
  end

  assign mem_wr    = 1'b0;
  assign mem_size  = MemSize;
  assign mem_wstrb = MemWstrb;
  assign mem_wdata = '0;

endmodule
